adc_lvds_tx_emu: RTL and testbench

Synthesizable transmitter for the multi-lane serial ADC link: bit clock, frame clock, sync and per-lane serial data.
- Serializes parallel sample words from an AXI-Stream-style input onto LANES single-ended bit lanes.
- Generates the companion bit clock (dclk_out), frame clock (fclk_out) and periodic sync pulse.
- Sits in front of the ADC glue receiver for loopback and bring-up without a physical ADC; LVDS buffers are instantiated outside the block.

---
 rtl/adc_lvds_tx_emu_if.sv | 12 +
 rtl/adc_lvds_tx_emu.sv | 155 +++++++++++++++
 tb/tb_adc_lvds_tx_emu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_lvds_tx_emu_if.sv
// Sample-word stream into the ADC link transmitter emulator.
interface adc_lvds_tx_emu_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned BITS  = 12
);
  logic [LANES*BITS-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/adc_lvds_tx_emu.sv
// Multi-lane serial ADC link transmitter: bit clock, frame clock, sync and MSB-first lane data.
// Optional ramp test pattern on the test_mode input when ADC_TX_TESTPAT_EN is defined.
module adc_lvds_tx_emu #(
  parameter int unsigned LANES       = 8,
  parameter int unsigned BITS        = 12,
  parameter int unsigned SYNC_PERIOD = 32,
  parameter int unsigned SYNC_BITS   = 3,
  parameter int unsigned IDLE_WORD   = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
`ifdef ADC_TX_TESTPAT_EN
  input  logic               test_mode,
`endif
  adc_lvds_tx_emu_if.slave   s,
  output logic               dclk_out,
  output logic               fclk_out,
  output logic [LANES-1:0]   d_out,
  output logic               sync_out,
  output logic               frame_start,
  output logic [15:0]        underrun_cnt
);

  localparam int unsigned CNT_W = $clog2(BITS);
  localparam int unsigned NB_W  = CNT_W + 1;
  localparam int unsigned FC_W  = $clog2(SYNC_PERIOD);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef logic [LANES-1:0][BITS-1:0] words_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             ph;
  logic [FC_W-1:0]  frame_cnt;
  words_t           sh;
  words_t           load_c;
  logic             tp_c;
  logic             last_c;
  logic [NB_W-1:0]  nb_c;
  logic [FC_W-1:0]  fc_next_c;

`ifdef ADC_TX_TESTPAT_EN
  logic [BITS-1:0]  ramp;
  assign tp_c = test_mode;
`else
  assign tp_c = 1'b0;
`endif

  assign last_c    = (state == SHIFT) && ph && (bit_cnt == CNT_W'(BITS - 1));
  assign nb_c      = {1'b0, bit_cnt} + NB_W'(1);
  assign fc_next_c = (frame_cnt == FC_W'(SYNC_PERIOD - 1)) ? '0 : frame_cnt + FC_W'(1);

  // Ready only while idle or on the final cycle of a frame; held low in reset and test pattern mode.
  assign s.s_tready = !resetn && enable && !tp_c && ((state == IDLE) || last_c);

  // Next-frame words: stream data, idle word on underrun, or ramp in test mode.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      load_c[k] = s.s_tvalid ? s.s_tdata[k*BITS +: BITS] : BITS'(IDLE_WORD);
    end
`ifdef ADC_TX_TESTPAT_EN
    if (test_mode) begin
      for (int k = 0; k < int'(LANES); k++) begin
        load_c[k] = ramp + BITS'(k);
      end
    end
`endif
  end

  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      d_out[k] = sh[k][BITS-1];
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      ph           <= 1'b0;
      frame_cnt    <= '0;
      sh           <= '0;
      dclk_out     <= 1'b0;
      fclk_out     <= 1'b0;
      sync_out     <= 1'b0;
      frame_start  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (s.s_tvalid || tp_c)) begin
            state       <= SHIFT;
            bit_cnt     <= '0;
            ph          <= 1'b0;
            frame_cnt   <= '0;
            sh          <= load_c;
            frame_start <= 1'b1;
            fclk_out    <= 1'b1;
            sync_out    <= 1'b1;
          end
        end
        SHIFT: begin
          if (!ph) begin
            ph       <= 1'b1;
            dclk_out <= 1'b1;
          end else begin
            ph       <= 1'b0;
            dclk_out <= 1'b0;
            if (!last_c) begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              for (int k = 0; k < int'(LANES); k++) begin
                sh[k] <= {sh[k][BITS-2:0], 1'b0};
              end
              fclk_out <= nb_c < NB_W'(BITS / 2);
              sync_out <= (frame_cnt == '0) && (nb_c < NB_W'(SYNC_BITS));
            end else if (!enable) begin
              state     <= IDLE;
              bit_cnt   <= '0;
              frame_cnt <= '0;
              sh        <= '0;
              fclk_out  <= 1'b0;
              sync_out  <= 1'b0;
            end else begin
              // Frame boundary: next frame follows with no gap cycle.
              bit_cnt     <= '0;
              frame_cnt   <= fc_next_c;
              sh          <= load_c;
              frame_start <= 1'b1;
              fclk_out    <= 1'b1;
              sync_out    <= (fc_next_c == '0);
              if (!s.s_tvalid && !tp_c && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_TX_TESTPAT_EN
  // Ramp advances once per test-pattern frame loaded.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ramp <= '0;
    end else if (enable && test_mode && ((state == IDLE) || last_c)) begin
      ramp <= ramp + BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_adc_lvds_tx_emu.sv
// Directed bench for adc_lvds_tx_emu: reset, framing, sync, underrun, enable drop, mid-frame reset.
module tb_adc_lvds_tx_emu;
  localparam int unsigned LANES = 8;
  localparam int unsigned BITS  = 12;

  logic              clk;
  logic              resetn;
  logic              enable;
  logic              dclk_out;
  logic              fclk_out;
  logic [LANES-1:0]  d_out;
  logic              sync_out;
  logic              frame_start;
  logic [15:0]       underrun_cnt;
`ifdef ADC_TX_TESTPAT_EN
  logic              test_mode;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  adc_lvds_tx_emu_if #(.LANES(LANES), .BITS(BITS)) sif ();

  adc_lvds_tx_emu #(
    .LANES(LANES), .BITS(BITS), .SYNC_PERIOD(32), .SYNC_BITS(3), .IDLE_WORD('h5A3)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
`ifdef ADC_TX_TESTPAT_EN
    .test_mode    (test_mode),
`endif
    .s            (sif.slave),
    .dclk_out     (dclk_out),
    .fclk_out     (fclk_out),
    .d_out        (d_out),
    .sync_out     (sync_out),
    .frame_start  (frame_start),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one 24-cycle frame from its first cycle, collecting lane words and strobes on dclk-high cycles.
  task automatic run_frame(input int drop_at,
                           output logic [11:0] w0, output logic [11:0] w3,
                           output logic [11:0] fw, output logic [11:0] sw,
                           output int fs, output int rdy, output int rpos, output int dbad);
    w0 = '0; w3 = '0; fw = '0; sw = '0;
    fs = 0; rdy = 0; rpos = -1; dbad = 0;
    for (int i = 0; i < 24; i++) begin
      if (dclk_out !== i[0]) dbad++;
      if (i[0]) begin
        w0 = {w0[10:0], d_out[0]};
        w3 = {w3[10:0], d_out[3]};
        fw = {fw[10:0], fclk_out};
        sw = {sw[10:0], sync_out};
      end
      if (frame_start === 1'b1) fs++;
      if (sif.s_tready === 1'b1) begin
        rdy++;
        rpos = i;
      end
      if (i == drop_at) enable = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [11:0] w0, w3, fw, sw;
    int fs, rdy, rpos, db;
    int bad, rdy_tot, fs_tot, db_tot, sync_frames, wbad;

    resetn = 1'b1;
    enable = 1'b0;
    sif.s_tvalid = 1'b0;
    sif.s_tdata  = '0;
`ifdef ADC_TX_TESTPAT_EN
    test_mode = 1'b0;
`endif
    for (int k = 0; k < int'(LANES); k++) sif.s_tdata[k*BITS +: BITS] = 12'(12'h111 * k);
    repeat (3) tick();
    chk("rst_outs", {27'(0), dclk_out, fclk_out, sync_out, frame_start} | 32'(d_out), 32'd0);
    chk("rst_ready", 32'(sif.s_tready), 32'd0);
    chk("rst_urun", 32'(underrun_cnt), 32'd0);

    // Enabled but no valid: stays idle, no underruns counted.
    resetn = 1'b0;
    enable = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if ({dclk_out, fclk_out, sync_out, frame_start, d_out} !== '0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("idle_ready", 32'(sif.s_tready), 32'd1);
    chk("idle_urun", 32'(underrun_cnt), 32'd0);

    // First frame carries 0xA5C; the word presented next is taken at the frame boundary.
    sif.s_tdata[11:0] = 12'hA5C;
    sif.s_tvalid = 1'b1;
    tick();
    sif.s_tdata[11:0] = 12'h3C7;
    run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
    chk("f0_word", 32'(w0), 32'hA5C);
    chk("f0_fclk", 32'(fw), 32'hFC0);
    chk("f0_sync", 32'(sw), 32'hE00);
    chk("f0_fstart", 32'(fs), 32'd1);
    chk("f0_ready_cnt", 32'(rdy), 32'd1);
    chk("f0_ready_pos", 32'(rpos), 32'd23);
    chk("f0_dclk", 32'(db), 32'd0);

    // Frames 1..39 back to back.
    rdy_tot = 0; fs_tot = 0; db_tot = 0; sync_frames = 0; wbad = 0;
    for (int f = 1; f < 40; f++) begin
      run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
      rdy_tot += rdy; fs_tot += fs; db_tot += db;
      if (w0 !== 12'h3C7) wbad++;
      if (sw !== 12'h000) sync_frames++;
      if (f == 32) chk("f32_sync", 32'(sw), 32'hE00);
      if (rpos != 23) wbad++;
    end
    chk("run_words", 32'(wbad), 32'd0);
    chk("run_ready", 32'(rdy_tot), 32'd39);
    chk("run_fstart", 32'(fs_tot), 32'd39);
    chk("run_sync_frames", 32'(sync_frames), 32'd1);
    chk("run_dclk", 32'(db_tot), 32'd0);

    // Valid dropped during frames 40..42: frames 41..43 send the idle word.
    sif.s_tvalid = 1'b0;
    db_tot = 0;
    run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
    db_tot += db;
    chk("f40_word", 32'(w0), 32'h3C7);
    run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
    db_tot += db;
    chk("f41_idle_word", 32'(w0), 32'h5A3);
    run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
    db_tot += db;
    chk("f42_idle_word", 32'(w0), 32'h5A3);
    sif.s_tvalid = 1'b1;
    sif.s_tdata[11:0] = 12'h0F1;
    run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
    db_tot += db;
    chk("f43_idle_word", 32'(w0), 32'h5A3);
    chk("urun_cnt", 32'(underrun_cnt), 32'd3);
    chk("urun_dclk", 32'(db_tot), 32'd0);

    // Enable dropped at bit 4 of frame 44: frame completes, no word taken, then idle.
    run_frame(8, w0, w3, fw, sw, fs, rdy, rpos, db);
    chk("drop_word", 32'(w0), 32'h0F1);
    chk("drop_ready", 32'(rdy), 32'd0);
    chk("drop_dclk", 32'(db), 32'd0);
    bad = 0;
    repeat (5) begin
      if ({dclk_out, fclk_out, sync_out, frame_start, d_out} !== '0) bad++;
      tick();
    end
    chk("drop_idle", 32'(bad), 32'd0);
    chk("drop_urun", 32'(underrun_cnt), 32'd3);

    // Reset asserted mid-frame clears outputs at once.
    enable = 1'b1;
    tick();
    repeat (6) tick();
    chk("pre_rst_fclk", 32'(fclk_out), 32'd1);
    resetn = 1'b1;
    #1;
    chk("midrst_outs", {27'(0), dclk_out, fclk_out, sync_out, frame_start} | 32'(d_out), 32'd0);
    chk("midrst_urun", 32'(underrun_cnt), 32'd0);
    chk("midrst_ready", 32'(sif.s_tready), 32'd0);
    tick();
    enable = 1'b0;
    resetn = 1'b0;

`ifdef ADC_TX_TESTPAT_EN
    // Ramp pattern: lane 3 carries ramp+3, stream never acknowledged.
    test_mode = 1'b1;
    enable = 1'b1;
    #1;
    chk("tp_idle_ready", 32'(sif.s_tready), 32'd0);
    tick();
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, w0, w3, fw, sw, fs, rdy, rpos, db);
      chk("tp_lane3", 32'(w3), 32'(3 + f));
      chk("tp_ready", 32'(rdy), 32'd0);
    end
    chk("tp_urun", 32'(underrun_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
